op_log_to_linear: RTL and testbench

- Downstream neighbour of the operator sine lookup.
- Takes the 14-bit sign + log-attenuation word from the sine lookup and adds the per-slot envelope/total-level attenuation, saturating the sum.
- Converts the result to a signed linear amplitude through an exponential table with linear interpolation.
- 3-stage pipeline gated by the operator clock enable; its output feeds the feedback/modulation path and the channel mixer.

---
 rtl/op_log_to_linear_if.sv | 23 ++
 rtl/op_log_to_linear.sv | 125 ++++++++++++
 tb/tb_op_log_to_linear.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/op_log_to_linear_if.sv
// Sample bus between the operator sine lookup, the log-to-linear stage and its consumers.
// The master drives a log-domain sample in; the slave returns the linear amplitude.
interface op_log_to_linear_if #(
    parameter int TAG_W = 5
);
    logic                    in_valid;
    logic [TAG_W-1:0]        in_slot;
    logic [13:0]             in_data;
    logic [6:0]              in_att;
    logic                    out_valid;
    logic [TAG_W-1:0]        out_slot;
    logic signed [9:0]       out_data;

    modport master (
        output in_valid, in_slot, in_data, in_att,
        input  out_valid, out_slot, out_data
    );

    modport slave (
        input  in_valid, in_slot, in_data, in_att,
        output out_valid, out_slot, out_data
    );
endinterface

// File: rtl/op_log_to_linear.sv
// Operator log-attenuation to signed linear amplitude: add envelope/TL attenuation,
// then exponentiate through a 2^(-n/8) table with linear interpolation (3-stage pipeline).
module op_log_to_linear #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clkena,
    op_log_to_linear_if.slave bus
);

    // Returns {zero_flag, saturated 7.6 attenuation}.
    function automatic logic [13:0] sat_sum(input logic [12:0] mag, input logic [6:0] att);
        logic [13:0] s;
        s = {1'b0, mag} + {1'b0, att, 6'b0};
        if (s[13])
            return {1'b1, 13'h1FFF};
        return {1'b0, s[12:0]};
    endfunction

    // round(511 * 2^(-n/8)); mantissas are 511*2^(-k/8) in Q16, octave j is a right shift.
    function automatic logic [8:0] exp_tab(input logic [7:0] n);
        logic [31:0] m;
        logic [4:0]  sh;
        case (n[2:0])
            3'd0:    m = 32'd33488896;
            3'd1:    m = 32'd30709453;
            3'd2:    m = 32'd28160693;
            3'd3:    m = 32'd25823469;
            3'd4:    m = 32'd23680225;
            3'd5:    m = 32'd21714862;
            3'd6:    m = 32'd19912617;
            default: m = 32'd18259950;
        endcase
        sh = 5'd16 + {1'b0, n[6:3]};
        if (n[7])
            return 9'd0;
        return 9'((m + (32'd1 << (sh - 5'd1))) >> sh);
    endfunction

    function automatic logic [8:0] interp(input logic [8:0] a, input logic [8:0] b,
                                          input logic [5:0] vf);
        logic [5:0]  d;
        logic [11:0] p;
        d = 6'(a - b);
        p = {6'b0, d} * {6'b0, vf};
        return a - 9'(p >> 6);
    endfunction

    function automatic logic signed [9:0] apply_sign(input logic sign, input logic [8:0] lin);
        logic signed [9:0] m;
        m = signed'({1'b0, lin});
        return sign ? -m : m;
    endfunction

    logic              r_sign_p1, r_z_p1, r_vld_p1;
    logic [6:0]        r_vi_p1;
    logic [5:0]        r_vf_p1;
    logic [TAG_W-1:0]  r_slot_p1;

    logic              r_sign_p2, r_z_p2, r_vld_p2;
    logic [8:0]        r_a_p2, r_b_p2;
    logic [5:0]        r_vf_p2;
    logic [TAG_W-1:0]  r_slot_p2;

    logic signed [9:0] r_data_p3;
    logic              r_vld_p3;
    logic [TAG_W-1:0]  r_slot_p3;

    logic [13:0]       w_sum;
    logic [8:0]        w_a, w_b, w_lin;
    logic signed [9:0] w_data;

    assign w_sum  = sat_sum(bus.in_data[12:0], bus.in_att);
    assign w_a    = exp_tab({1'b0, r_vi_p1});
    assign w_b    = exp_tab({1'b0, r_vi_p1} + 8'd1);
    assign w_lin  = r_z_p2 ? 9'd0 : interp(r_a_p2, r_b_p2, r_vf_p2);
    assign w_data = apply_sign(r_sign_p2, w_lin);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign_p1 <= 1'b0;
            r_z_p1    <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_vi_p1   <= '0;
            r_vf_p1   <= '0;
            r_slot_p1 <= '0;
            r_sign_p2 <= 1'b0;
            r_z_p2    <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_a_p2    <= '0;
            r_b_p2    <= '0;
            r_vf_p2   <= '0;
            r_slot_p2 <= '0;
            r_data_p3 <= '0;
            r_vld_p3  <= 1'b0;
            r_slot_p3 <= '0;
        end else if (clkena) begin
            // Stage 1: attenuation sum with saturation
            r_sign_p1 <= bus.in_data[13];
            r_z_p1    <= w_sum[13];
            r_vi_p1   <= w_sum[12:6];
            r_vf_p1   <= w_sum[5:0];
            r_vld_p1  <= bus.in_valid;
            r_slot_p1 <= bus.in_slot;
            // Stage 2: table lookup of the two bracketing points
            r_sign_p2 <= r_sign_p1;
            r_z_p2    <= r_z_p1;
            r_a_p2    <= w_a;
            r_b_p2    <= w_b;
            r_vf_p2   <= r_vf_p1;
            r_vld_p2  <= r_vld_p1;
            r_slot_p2 <= r_slot_p1;
            // Stage 3: interpolation and sign
            r_data_p3 <= w_data;
            r_vld_p3  <= r_vld_p2;
            r_slot_p3 <= r_slot_p2;
        end
    end

    assign bus.out_valid = r_vld_p3;
    assign bus.out_slot  = r_slot_p3;
    assign bus.out_data  = r_data_p3;

endmodule

// File: tb/tb_op_log_to_linear.sv
// Scoreboard bench for op_log_to_linear: directed vectors push expected results,
// a monitor pops and compares on every clkena-qualified output edge.
module tb_op_log_to_linear;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic reset;
    logic clkena;

    always #5 clk = ~clk;

    op_log_to_linear_if #(.TAG_W(TAG_W)) bus();

    op_log_to_linear #(.TAG_W(TAG_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .clkena (clkena),
        .bus    (bus)
    );

    typedef struct {
        logic [TAG_W-1:0] slot;
        int               data;
        int               due;
    } exp_t;

    typedef struct {
        logic [13:0] d;
        logic [6:0]  a;
        int          e;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   en_cnt   = 0;

    // Hand-computed expectations: T[n] = round(511*2^(-n/8)), lin = a - ((a-b)*vf >> 6).
    vec_t vt[16] = '{
        '{14'h0000, 7'd0,   511},
        '{14'h2200, 7'd0,  -256},
        '{14'h2200, 7'd8,  -128},
        '{14'h0020, 7'd0,   490},
        '{14'h1900, 7'd60,    0},
        '{14'h3FFF, 7'd0,     0},
        '{14'h3FFF, 7'd127,   0},
        '{14'h0000, 7'd24,   64},
        '{14'h0040, 7'd0,   469},
        '{14'h2220, 7'd0,  -245},
        '{14'h0000, 7'd79,    1},
        '{14'h0000, 7'd80,    0},
        '{14'h33C0, 7'd0,    -1},
        '{14'h1FC0, 7'd1,     0},
        '{14'h0400, 7'd0,   128},
        '{14'h1FFF, 7'd0,     0}
    };

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic v, input logic [TAG_W-1:0] slot,
                         input logic [13:0] data, input logic [6:0] att, input int exp);
        @(negedge clk);
        clkena       = en;
        bus.in_valid = v;
        bus.in_slot  = slot;
        bus.in_data  = data;
        bus.in_att   = att;
        if (en && v && !reset)
            sb.push_back('{slot: slot, data: exp, due: en_cnt + 3});
    endtask

    initial begin : monitor
        logic en, rs, pv;
        int   pd, ps;
        exp_t e;
        pv = 1'b0;
        pd = 0;
        ps = 0;
        forever begin
            @(posedge clk);
            en = clkena;
            rs = reset;
            #1;
            if (rs) begin
                check("reset_out_valid", int'(bus.out_valid), 0);
                check("reset_out_data", int'(bus.out_data), 0);
                check("reset_out_slot", int'(bus.out_slot), 0);
            end else if (en) begin
                en_cnt++;
                if (bus.out_valid) begin
                    if (sb.size() == 0) begin
                        check("out_valid_unexpected", int'(bus.out_valid), 0);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", int'(bus.out_data), e.data);
                        check("out_slot", int'(bus.out_slot), int'(e.slot));
                        check("latency_edge", en_cnt, e.due);
                    end
                end else if (sb.size() > 0 && sb[0].due <= en_cnt) begin
                    e = sb.pop_front();
                    check("out_valid_missing", int'(bus.out_valid), 1);
                end
            end else begin
                check("hold_out_valid", int'(bus.out_valid), int'(pv));
                check("hold_out_data", int'(bus.out_data), pd);
                check("hold_out_slot", int'(bus.out_slot), ps);
            end
            pv = bus.out_valid;
            pd = int'(bus.out_data);
            ps = int'(bus.out_slot);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic en_pat[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int   pick[4]   = '{0, 3, 8, 1};
        int   k;
        reset        = 1'b1;
        clkena       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_slot  = '0;
        bus.in_data  = '0;
        bus.in_att   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Back-to-back directed vectors with an invalid bubble
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, TAG_W'(i + 3), vt[i].d, vt[i].a, vt[i].e);
            if (i == 5)
                drive(1'b1, 1'b0, 5'd30, 14'h0000, 7'd0, 0);
        end
        repeat (4) drive(1'b1, 1'b0, 5'd0, 14'h0000, 7'd0, 0);

        // clkena toggling; held inputs during clkena=0 must not be taken
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if (en_pat[i] && k < 4) begin
                drive(1'b1, 1'b1, TAG_W'(20 + k), vt[pick[k]].d, vt[pick[k]].a, vt[pick[k]].e);
                k++;
            end else if (en_pat[i]) begin
                drive(1'b1, 1'b0, 5'd0, 14'h0000, 7'd0, 0);
            end else begin
                drive(1'b0, 1'b1, 5'd31, vt[2].d, vt[2].a, vt[2].e);
            end
        end
        repeat (4) drive(1'b1, 1'b0, 5'd0, 14'h0000, 7'd0, 0);

        // Reset with two samples in flight
        drive(1'b1, 1'b1, 5'd10, 14'h0000, 7'd0, 511);
        drive(1'b1, 1'b1, 5'd11, 14'h0040, 7'd0, 469);
        @(negedge clk);
        reset        = 1'b1;
        clkena       = 1'b1;
        bus.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        reset  = 1'b0;
        clkena = 1'b0;

        // Fresh sample after reset, latency counted in clkena cycles
        drive(1'b1, 1'b1, 5'd12, 14'h2200, 7'd8, -128);
        drive(1'b1, 1'b0, 5'd0, 14'h0000, 7'd0, 0);
        drive(1'b0, 1'b0, 5'd0, 14'h0000, 7'd0, 0);
        repeat (4) drive(1'b1, 1'b0, 5'd0, 14'h0000, 7'd0, 0);

        @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
